decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Pipelined ID stage sitting directly downstream of instruction fetch. Holds IF/ID register,
//  decodes opcode/func, drives register-file read ports, detects load-use hazards, resolves
//  j in ID, and loads the ID/EX register consumed by the EX stage (alu).
// PARAMETERS
//  PC_W    30  word-address PC width (byte address = {pc,2'b00})
//  XLEN    32  datapath width
// PORTS
//  clk             in   1     rising-edge clock
//  rst_n           in   1     async active-low reset
//  if_valid        in   1     fetch presents a real instruction this cycle
//  if_pc           in   PC_W  word PC of if_instr
//  if_instr        in   32    fetched instruction
//  if_stall        out  1     hold PC and fetch output this cycle (load-use)
//  flush           in   1     EX taken branch: kill IF/ID and ID/EX contents
//  rf_addr_a       out  5     rs, comb. from IF/ID
//  rf_addr_b       out  5     rt, comb. from IF/ID
//  rf_data_a       in   XLEN  register file read data A (comb.)
//  rf_data_b       in   XLEN  register file read data B (comb.)
//  wb_reg_write    in   1     WB stage writes wb_addr this cycle
//  wb_addr         in   5     WB destination
//  wb_data         in   XLEN  WB data
//  id_jump         out  1     j in ID: redirect fetch, squash IF/ID
//  id_jump_target  out  PC_W  {(id_pc+1)[PC_W-1:26], addr26}
//  ex_valid        out  1     ID/EX holds a real instruction
//  ex_pc           out  PC_W  PC of ID/EX instruction
//  ex_data_a       out  XLEN  operand A
//  ex_data_b       out  XLEN  operand B (rt value; also sw store data)
//  ex_imm32        out  XLEN  sign-extended imm16
//  ex_dest         out  5     destination register (rd for R-type, rt for lw/addi, 0 otherwise)
//  ex_shamt        out  5     instr[10:6]
//  ex_alu_op       out  3     000 and,001 or,010 add,110 sub,111 slt
//  ex_ctrl         out  7     {illegal,branch,mem_to_reg,mem_write,mem_read,reg_write,alu_src_imm}
// BEHAVIOUR
//  - Reset (async, rst_n=0): IF/ID valid=0, all ex_* = 0, if_stall=0, id_jump=0.
//  - Latency: instr at if_* before edge N enters IF/ID at N; ID/EX loaded at N+1.
//  - Decode: R-type(op 0) func 100000 add,100010 sub,100100 and,100101 or,101010 slt;
//    lw 100011 (add,imm,mem_read,mem_to_reg,reg_write); sw 101011 (add,imm,mem_write);
//    beq 000100 (sub,branch); addi 001000 (add,imm,reg_write); j 000010 (no EX effect).
//    Anything else: illegal=1, all write/mem enables 0, ex_valid=1.
//  - ex_dest==0 forces reg_write=0 (writes to $0 never issued).
//  - Load-use: stall = ifid_valid & ex_valid & ex_ctrl.mem_read & ex_dest!=0 &
//    (ex_dest==rs | (ex_dest==rt & instr reads rt: R-type,sw,beq)). On stall: IF/ID holds,
//    ID/EX loads bubble (ex_valid=0, ex_ctrl=0), if_stall=1. Stall lasts exactly one cycle.
//  - id_jump = ifid_valid & op==j & ~stall & ~flush. On id_jump: IF/ID loads invalid next
//    edge (no delay slot); j itself issues to EX as bubble.
//  - Priority: flush > stall > jump. flush: IF/ID and ID/EX both load invalid, if_stall=0.
//  - if_valid=0: IF/ID loads invalid; invalid IF/ID issues bubble to ID/EX.
//  - Arithmetic: imm32 = {{16{imm16[15]}},imm16}; id_jump_target wraps mod 2^PC_W.
// CONFIGURATION
//  DECODE_WB_BYPASS_EN defined: if wb_reg_write & wb_addr!=0 & wb_addr==rs (rt), ex_data_a (b)
//   takes wb_data instead of rf_data_a (b) (same-cycle write/read bypass).
//  Undefined: ex_data_a/b = rf_data_a/b unmodified; same-cycle WB write not visible.
// STRUCTURE
//  Package pipeline_pkg: OP_*/FUNC_* constants, ALU_* encodings, ex_ctrl bit indices,
//   id_ex_t struct. Reused by fetch, EX and hazard logic.
//  Sub-module decode_ctrl: combinational opcode/func -> alu_op, ctrl, dest-select, reads_rt.
//  Top holds IF/ID reg, hazard/jump logic, ID/EX reg.
// TESTING
//  1 Reset mid-stream: rst_n=0 with IF/ID and ID/EX valid -> ex_valid=0, ex_ctrl=0 at once.
//  2 add $3,$1,$2 (0x00221820), r1=5,r2=7 -> next cycle ex_data_a=5, ex_data_b=7,
//    ex_alu_op=010, ex_dest=3, ex_ctrl=7'b0000010.
//  3 lw $4,8($0) then add $5,$4,$4 -> one cycle if_stall=1, bubble in EX, add issues next
//    cycle with ex_dest=5; no second stall.
//  4 j 0x0000040 at pc=0x10 -> id_jump=1, target=0x40; following fetched instr never ex_valid.
//  5 flush=1 while stall active -> both regs invalid, if_stall=0 same cycle.
//  6 wb writes r1=9 while add reads r1 (rf still 5) -> ex_data_a=9 with DECODE_WB_BYPASS_EN,
//    5 without.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared opcode/func constants, ALU encodings, ex_ctrl bit indices and the ID/EX record
package pipeline_pkg;
  localparam int PC_W = 30;
  localparam int XLEN = 32;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_SUB = 6'h22;
  localparam logic [5:0] FUNC_AND = 6'h24;
  localparam logic [5:0] FUNC_OR  = 6'h25;
  localparam logic [5:0] FUNC_SLT = 6'h2a;
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;
  typedef enum logic [1:0] {DEST_NONE, DEST_RD, DEST_RT} dest_sel_t;
  localparam int C_ALU_SRC_IMM = 0;
  localparam int C_REG_WRITE   = 1;
  localparam int C_MEM_READ    = 2;
  localparam int C_MEM_WRITE   = 3;
  localparam int C_MEM_TO_REG  = 4;
  localparam int C_BRANCH      = 5;
  localparam int C_ILLEGAL     = 6;
  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] data_a;
    logic [XLEN-1:0] data_b;
    logic [XLEN-1:0] imm32;
    logic [4:0]      dest;
    logic [4:0]      shamt;
    alu_op_t         alu_op;
    logic [6:0]      ctrl;
  } id_ex_t;
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch <-> decode bus
//   master (fetch): drives if_valid, if_pc, if_instr; sees if_stall, id_jump, id_jump_target
//   slave (decode): the reverse
interface decode_stage_if;
  logic                         if_valid;
  logic [pipeline_pkg::PC_W-1:0] if_pc;
  logic [31:0]                  if_instr;
  logic                         if_stall;
  logic                         id_jump;
  logic [pipeline_pkg::PC_W-1:0] id_jump_target;
  modport master(output if_valid, if_pc, if_instr, input if_stall, id_jump, id_jump_target);
  modport slave(input if_valid, if_pc, if_instr, output if_stall, id_jump, id_jump_target);
endinterface

// File: rtl/decode_ctrl.sv
// decode_ctrl: combinational opcode/func decode
//   op, func  : instruction fields
//   alu_op    : ALU operation for EX
//   ctrl      : {illegal,branch,mem_to_reg,mem_write,mem_read,reg_write,alu_src_imm}
//   dest_sel  : which field names the destination register
//   reads_rt  : instruction consumes the rt register value
module decode_ctrl
  import pipeline_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output alu_op_t    alu_op,
  output logic [6:0] ctrl,
  output dest_sel_t  dest_sel,
  output logic       reads_rt
);
  always_comb begin
    alu_op = ALU_ADD;
    ctrl = '0;
    dest_sel = DEST_NONE;
    reads_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    case (op)
      OP_RTYPE: begin
        dest_sel = DEST_RD;
        ctrl[C_REG_WRITE] = 1'b1;
        case (func)
          FUNC_ADD: alu_op = ALU_ADD;
          FUNC_SUB: alu_op = ALU_SUB;
          FUNC_AND: alu_op = ALU_AND;
          FUNC_OR:  alu_op = ALU_OR;
          FUNC_SLT: alu_op = ALU_SLT;
          default: begin
            ctrl = '0;
            ctrl[C_ILLEGAL] = 1'b1;
            dest_sel = DEST_NONE;
          end
        endcase
      end
      OP_LW: begin
        ctrl[C_ALU_SRC_IMM] = 1'b1;
        ctrl[C_REG_WRITE] = 1'b1;
        ctrl[C_MEM_READ] = 1'b1;
        ctrl[C_MEM_TO_REG] = 1'b1;
        dest_sel = DEST_RT;
      end
      OP_SW: begin
        ctrl[C_ALU_SRC_IMM] = 1'b1;
        ctrl[C_MEM_WRITE] = 1'b1;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        ctrl[C_BRANCH] = 1'b1;
      end
      OP_ADDI: begin
        ctrl[C_ALU_SRC_IMM] = 1'b1;
        ctrl[C_REG_WRITE] = 1'b1;
        dest_sel = DEST_RT;
      end
      OP_J: ;
      default: ctrl[C_ILLEGAL] = 1'b1;
    endcase
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: ID stage - IF/ID register, decode, load-use stall, j resolution, ID/EX register
//   clk, rst_n          : clock, async active-low reset
//   fetch (slave)       : if_valid/if_pc/if_instr in; if_stall, id_jump, id_jump_target out
//   flush               : EX taken branch, kills IF/ID and ID/EX
//   rf_addr_*/rf_data_* : register-file read ports (rs, rt)
//   wb_*                : WB write port, bypassed into operands when DECODE_WB_BYPASS_EN is defined
//   ex_*                : ID/EX register contents for the EX stage
module decode_stage
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  decode_stage_if.slave   fetch,
  input  logic            flush,
  output logic [4:0]      rf_addr_a,
  output logic [4:0]      rf_addr_b,
  input  logic [XLEN-1:0] rf_data_a,
  input  logic [XLEN-1:0] rf_data_b,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc,
  output logic [XLEN-1:0] ex_data_a,
  output logic [XLEN-1:0] ex_data_b,
  output logic [XLEN-1:0] ex_imm32,
  output logic [4:0]      ex_dest,
  output logic [4:0]      ex_shamt,
  output logic [2:0]      ex_alu_op,
  output logic [6:0]      ex_ctrl
);
  logic            ifid_valid;
  logic [PC_W-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  id_ex_t          idex;
  id_ex_t          idex_d;
  logic [5:0]      op;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  alu_op_t         alu_op;
  logic [6:0]      ctrl;
  dest_sel_t       dest_sel;
  logic            reads_rt;
  logic [4:0]      dest;
  logic            stall;
  logic            jump;
  logic [XLEN-1:0] data_a;
  logic [XLEN-1:0] data_b;
  assign op = ifid_instr[31:26];
  assign rs = ifid_instr[25:21];
  assign rt = ifid_instr[20:16];
  assign rd = ifid_instr[15:11];
  assign rf_addr_a = rs;
  assign rf_addr_b = rt;
  decode_ctrl u_ctrl (
    .op(op),
    .func(ifid_instr[5:0]),
    .alu_op(alu_op),
    .ctrl(ctrl),
    .dest_sel(dest_sel),
    .reads_rt(reads_rt)
  );
  assign dest = dest_sel == DEST_RD ? rd : dest_sel == DEST_RT ? rt : 5'd0;
  // The rs compare applies to every opcode, so a j whose address bits alias the load
  // destination also waits one cycle; that is harmless and keeps the check uniform.
  assign stall = ifid_valid && idex.valid && idex.ctrl[C_MEM_READ] && idex.dest != 5'd0 &&
                 (idex.dest == rs || (idex.dest == rt && reads_rt));
  assign jump = ifid_valid && op == OP_J && !stall && !flush;
  assign fetch.if_stall = stall && !flush;
  assign fetch.id_jump = jump;
  // (pc+1) only affects bits above 26 through the carry out of the low 26 bits.
  assign fetch.id_jump_target = {ifid_pc[PC_W-1:26] + (PC_W-26)'(&ifid_pc[25:0]), ifid_instr[25:0]};
`ifdef DECODE_WB_BYPASS_EN
  assign data_a = (wb_reg_write && wb_addr != 5'd0 && wb_addr == rs) ? wb_data : rf_data_a;
  assign data_b = (wb_reg_write && wb_addr != 5'd0 && wb_addr == rt) ? wb_data : rf_data_b;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write, wb_addr, wb_data};
  assign data_a = rf_data_a;
  assign data_b = rf_data_b;
`endif
  always_comb begin
    idex_d = '0;
    if (ifid_valid && !flush && !stall && op != OP_J) begin
      idex_d.valid = 1'b1;
      idex_d.pc = ifid_pc;
      idex_d.data_a = data_a;
      idex_d.data_b = data_b;
      idex_d.imm32 = {{16{ifid_instr[15]}}, ifid_instr[15:0]};
      idex_d.dest = dest;
      idex_d.shamt = ifid_instr[10:6];
      idex_d.alu_op = alu_op;
      idex_d.ctrl = ctrl;
      idex_d.ctrl[C_REG_WRITE] = ctrl[C_REG_WRITE] && dest != 5'd0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid <= 1'b0;
      ifid_pc <= '0;
      ifid_instr <= '0;
      idex <= '0;
    end else begin
      if (flush || jump) ifid_valid <= 1'b0;
      else if (!stall) begin
        ifid_valid <= fetch.if_valid;
        ifid_pc <= fetch.if_pc;
        ifid_instr <= fetch.if_instr;
      end
      idex <= idex_d;
    end
  end
  assign ex_valid = idex.valid;
  assign ex_pc = idex.pc;
  assign ex_data_a = idex.data_a;
  assign ex_data_b = idex.data_b;
  assign ex_imm32 = idex.imm32;
  assign ex_dest = idex.dest;
  assign ex_shamt = idex.shamt;
  assign ex_alu_op = idex.alu_op;
  assign ex_ctrl = idex.ctrl;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a transaction-level reference
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic [4:0]  rf_addr_a;
  logic [4:0]  rf_addr_b;
  logic [31:0] rf_data_a;
  logic [31:0] rf_data_b;
  logic        wb_reg_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [29:0] ex_pc;
  logic [31:0] ex_data_a;
  logic [31:0] ex_data_b;
  logic [31:0] ex_imm32;
  logic [4:0]  ex_dest;
  logic [4:0]  ex_shamt;
  logic [2:0]  ex_alu_op;
  logic [6:0]  ex_ctrl;
  logic [31:0] regs [32];
  int checks = 0;
  int errors = 0;
  decode_stage_if fi();
  decode_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch(fi),
    .flush(flush),
    .rf_addr_a(rf_addr_a),
    .rf_addr_b(rf_addr_b),
    .rf_data_a(rf_data_a),
    .rf_data_b(rf_data_b),
    .wb_reg_write(wb_reg_write),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .ex_valid(ex_valid),
    .ex_pc(ex_pc),
    .ex_data_a(ex_data_a),
    .ex_data_b(ex_data_b),
    .ex_imm32(ex_imm32),
    .ex_dest(ex_dest),
    .ex_shamt(ex_shamt),
    .ex_alu_op(ex_alu_op),
    .ex_ctrl(ex_ctrl)
  );
  always #5 clk = ~clk;
  assign rf_data_a = regs[rf_addr_a];
  assign rf_data_b = regs[rf_addr_b];
  // reference state: what sits in ID and what EX should currently see
  bit          m_v;
  logic [29:0] m_pc;
  logic [31:0] m_ins;
  bit          e_v;
  logic [29:0] e_pc;
  logic [31:0] e_a;
  logic [31:0] e_b;
  logic [31:0] e_imm;
  logic [4:0]  e_dest;
  logic [4:0]  e_sh;
  logic [2:0]  e_aop;
  logic [6:0]  e_ctrl;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic clear_ex();
    e_v = 0; e_pc = 0; e_a = 0; e_b = 0; e_imm = 0; e_dest = 0; e_sh = 0; e_aop = 0; e_ctrl = 0;
  endtask
  task automatic model_reset();
    m_v = 0; m_pc = 0; m_ins = 0;
    clear_ex();
  endtask
  // instruction meaning taken straight from the opcode table
  function automatic void ref_dec(input logic [31:0] ins, output logic [2:0] aop,
                                  output logic [6:0] c, output logic [4:0] dst, output bit rrt);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    aop = 3'b010;
    c = 7'b0;
    dst = 5'd0;
    rrt = (op == 6'h00 || op == 6'h2b || op == 6'h04);
    if (op == 6'h00) begin
      dst = ins[15:11];
      c = 7'b0000010;
      if (fn == 6'h20) aop = 3'b010;
      else if (fn == 6'h22) aop = 3'b110;
      else if (fn == 6'h24) aop = 3'b000;
      else if (fn == 6'h25) aop = 3'b001;
      else if (fn == 6'h2a) aop = 3'b111;
      else begin c = 7'b1000000; dst = 5'd0; end
    end else if (op == 6'h23) begin dst = ins[20:16]; c = 7'b0010111; end
    else if (op == 6'h2b) c = 7'b0001001;
    else if (op == 6'h04) begin c = 7'b0100000; aop = 3'b110; end
    else if (op == 6'h08) begin dst = ins[20:16]; c = 7'b0000011; end
    else if (op != 6'h02) c = 7'b1000000;
    if (dst == 5'd0) c[1] = 1'b0;
  endfunction
  function automatic logic [31:0] rd_val(input logic [4:0] r);
    rd_val = regs[r];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_reg_write && wb_addr != 5'd0 && wb_addr == r) rd_val = wb_data;
`endif
  endfunction
  // compare this cycle's outputs, then move the reference across the coming edge
  task automatic eval_cycle();
    logic [2:0] aop;
    logic [6:0] c;
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
    bit rrt;
    bit stall;
    bit jump;
    longint unsigned p;
    longint unsigned tgt;
    rs = m_ins[25:21];
    rt = m_ins[20:16];
    ref_dec(m_ins, aop, c, dst, rrt);
    stall = m_v && e_v && e_ctrl[2] && e_dest != 0 && (e_dest == rs || (e_dest == rt && rrt));
    jump = m_v && m_ins[31:26] == 6'h02 && !stall && !flush;
    chk("if_stall", fi.if_stall, stall && !flush);
    chk("id_jump", fi.id_jump, jump);
    if (jump) begin
      p = (longint'(m_pc) + 1) % (64'd1 << 30);
      tgt = (p / 64'd67108864) * 64'd67108864 + m_ins[25:0];
      chk("jump_target", fi.id_jump_target, tgt);
    end
    if (m_v) begin
      chk("rf_addr_a", rf_addr_a, rs);
      chk("rf_addr_b", rf_addr_b, rt);
    end
    chk("ex_valid", ex_valid, e_v);
    chk("ex_ctrl", ex_ctrl, e_ctrl);
    if (e_v) begin
      chk("ex_pc", ex_pc, e_pc);
      chk("ex_data_a", ex_data_a, e_a);
      chk("ex_data_b", ex_data_b, e_b);
      chk("ex_imm32", ex_imm32, e_imm);
      chk("ex_dest", ex_dest, e_dest);
      chk("ex_shamt", ex_shamt, e_sh);
      if (!e_ctrl[6]) chk("ex_alu_op", ex_alu_op, e_aop);
    end
    if (m_v && !flush && !stall && m_ins[31:26] != 6'h02) begin
      e_v = 1;
      e_pc = m_pc;
      e_a = rd_val(rs);
      e_b = rd_val(rt);
      e_imm = int'($signed(m_ins[15:0]));
      e_dest = dst;
      e_sh = m_ins[10:6];
      e_aop = aop;
      e_ctrl = c;
    end else clear_ex();
    if (flush || jump) m_v = 0;
    else if (!stall) begin
      m_v = fi.if_valid;
      m_pc = fi.if_pc;
      m_ins = fi.if_instr;
    end
  endtask
  task automatic step(input bit v, input logic [29:0] pc, input logic [31:0] ins, input bit fl);
    fi.if_valid = v;
    fi.if_pc = pc;
    fi.if_instr = ins;
    flush = fl;
    #1;
    eval_cycle();
    @(negedge clk);
  endtask
  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    r[25:21] = 5'($urandom_range(0, 7));
    r[20:16] = 5'($urandom_range(0, 7));
    r[15:11] = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0, 1: begin
        r[31:26] = 6'h00;
        case ($urandom_range(0, 5))
          0: r[5:0] = 6'h20;
          1: r[5:0] = 6'h22;
          2: r[5:0] = 6'h24;
          3: r[5:0] = 6'h25;
          4: r[5:0] = 6'h2a;
          default: ;
        endcase
      end
      2: r[31:26] = 6'h23;
      3: r[31:26] = 6'h2b;
      4: r[31:26] = 6'h04;
      5: r[31:26] = 6'h08;
      6: r[31:26] = 6'h02;
      default: ;
    endcase
    return r;
  endfunction
  initial begin
    fi.if_valid = 0;
    fi.if_pc = 0;
    fi.if_instr = 0;
    flush = 0;
    wb_reg_write = 0;
    wb_addr = 0;
    wb_data = 0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 0;
    regs[1] = 5;
    regs[2] = 7;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_ex_valid", ex_valid, 0);
    chk("reset_ex_ctrl", ex_ctrl, 0);
    chk("reset_if_stall", fi.if_stall, 0);
    chk("reset_id_jump", fi.id_jump, 0);
    rst_n = 1;
    step(1, 30'h0, 32'h00221820, 0);
    step(1, 30'h1, 32'h20060001, 0);
    chk("add_valid", ex_valid, 1);
    chk("add_data_a", ex_data_a, 5);
    chk("add_data_b", ex_data_b, 7);
    chk("add_alu_op", ex_alu_op, 3'b010);
    chk("add_dest", ex_dest, 3);
    chk("add_ctrl", ex_ctrl, 7'b0000010);
    rst_n = 0;
    #1;
    chk("midrst_ex_valid", ex_valid, 0);
    chk("midrst_ex_ctrl", ex_ctrl, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    step(1, 30'h20, 32'h8C040008, 0);
    step(1, 30'h21, 32'h00842820, 0);
    chk("lu_stall", fi.if_stall, 1);
    chk("lu_ex_lw", ex_ctrl, 7'b0010111);
    step(1, 30'h22, 32'h20060001, 0);
    chk("lu_bubble", ex_valid, 0);
    chk("lu_bubble_ctrl", ex_ctrl, 0);
    chk("lu_one_cycle", fi.if_stall, 0);
    step(1, 30'h22, 32'h20060001, 0);
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_dest", ex_dest, 5);
    chk("lu_no_restall", fi.if_stall, 0);
    step(1, 30'h10, 32'h08000040, 0);
    chk("j_jump", fi.id_jump, 1);
    chk("j_target", fi.id_jump_target, 30'h40);
    step(1, 30'h11, 32'h20070003, 0);
    chk("j_bubble", ex_valid, 0);
    step(1, 30'h40, 32'h20080004, 0);
    chk("j_squashed", ex_valid, 0);
    step(0, 30'h0, 32'h0, 0);
    chk("j_dest_valid", ex_valid, 1);
    chk("j_dest_pc", ex_pc, 30'h40);
    step(1, 30'h50, 32'h8C040008, 0);
    step(1, 30'h51, 32'h00842820, 0);
    chk("fl_pre_stall", fi.if_stall, 1);
    flush = 1;
    #1;
    chk("fl_if_stall", fi.if_stall, 0);
    step(1, 30'h52, 32'h20060001, 1);
    chk("fl_ex_valid", ex_valid, 0);
    step(1, 30'h53, 32'h20060001, 0);
    chk("fl_ifid_killed", ex_valid, 0);
    step(0, 30'h0, 32'h0, 0);
    chk("fl_resume_pc", ex_pc, 30'h53);
    step(1, 30'h60, 32'h00221820, 0);
    wb_reg_write = 1;
    wb_addr = 1;
    wb_data = 9;
    step(0, 30'h0, 32'h0, 0);
    wb_reg_write = 0;
`ifdef DECODE_WB_BYPASS_EN
    chk("wb_bypass_a", ex_data_a, 9);
`else
    chk("wb_bypass_a", ex_data_a, 5);
`endif
    for (int n = 0; n < 3000; n++) begin
      wb_reg_write = ($urandom_range(0, 3) == 0);
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      step($urandom_range(0, 9) != 0, 30'($urandom), rand_instr(), $urandom_range(0, 15) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
